btn_debouncer: RTL and testbench

//   Synchronises and debounces NUM_BTN raw push-button inputs. Outputs are clean, glitch-free levels.

---
 rtl/btn_debouncer.sv | 63 ++++++
 tb/tb_btn_debouncer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_debouncer.sv
// Two-flop synchroniser plus per-channel stability counter for raw push buttons.
// Produces a clean level and single-cycle press/release pulses per channel.
module btn_debouncer #(
  parameter int NUM_BTN       = 3,
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = 20,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] sync_s1;
  logic [NUM_BTN-1:0] sync_s2;
  logic [CNT_W-1:0]   cnt [NUM_BTN];

  // Polarity is folded in before the synchroniser so everything downstream sees 1 = pressed.
  assign btn_in = btn_raw ^ {NUM_BTN{ACTIVE_LOW}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= btn_in;
      sync_s2 <= sync_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync_s2[i] == btn_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          // New level has held for STABLE_CYCLES synchronised samples: accept it.
          btn_level[i]   <= sync_s2[i];
          btn_press[i]   <= sync_s2[i];
          btn_release[i] <= ~sync_s2[i];
          cnt[i]         <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_debouncer.sv
// Randomised and directed bench for btn_debouncer, both polarities, against a
// sample-window reference model.
module tb_btn_debouncer;

  localparam int N = 3;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] raw_h = '0;
  logic [N-1:0] raw_l = '1;
  logic [N-1:0] lvl_h, prs_h, rel_h;
  logic [N-1:0] lvl_l, prs_l, rel_l;

  int checks = 0;
  int errors = 0;

  // model state, index 0 = active-high instance, 1 = active-low instance
  logic [N-1:0] m_level [2];
  logic [N-1:0] m_press [2];
  logic [N-1:0] m_rel   [2];
  logic [N-1:0] in_log  [2][$];
  bit           win_q   [2*N][$];

  btn_debouncer #(.NUM_BTN(N), .STABLE_CYCLES(S), .CNT_W(2), .ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw_h),
    .btn_level(lvl_h), .btn_press(prs_h), .btn_release(rel_h)
  );

  btn_debouncer #(.NUM_BTN(N), .STABLE_CYCLES(S), .CNT_W(2), .ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw_l),
    .btn_level(lvl_l), .btn_press(prs_l), .btn_release(rel_l)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_level[k] = '0;
      m_press[k] = '0;
      m_rel[k]   = '0;
      in_log[k].delete();
    end
    for (int k = 0; k < 2*N; k++) win_q[k].delete();
  endtask

  // A level is accepted once the last S synchronised samples since the previous
  // acceptance all show the opposite value. The synchronised sample seen at an
  // edge is the pin value taken two edges earlier (zero right after reset).
  task automatic model_step(input int inst, input logic [N-1:0] bin);
    logic [N-1:0] s2;
    bit all_new;
    int k, sz;
    s2 = (in_log[inst].size() >= 2) ? in_log[inst][in_log[inst].size()-2] : '0;
    in_log[inst].push_back(bin);
    if (in_log[inst].size() > 2) void'(in_log[inst].pop_front());
    m_press[inst] = '0;
    m_rel[inst]   = '0;
    for (int c = 0; c < N; c++) begin
      k = inst*N + c;
      win_q[k].push_back(s2[c]);
      if (win_q[k].size() > S) void'(win_q[k].pop_front());
      sz = win_q[k].size();
      if (sz == S) begin
        all_new = 1'b1;
        for (int j = 0; j < S; j++)
          if (win_q[k][j] == m_level[inst][c]) all_new = 1'b0;
        if (all_new) begin
          m_level[inst][c] = ~m_level[inst][c];
          m_press[inst][c] = m_level[inst][c];
          m_rel[inst][c]   = ~m_level[inst][c];
          win_q[k].delete();
        end
      end
    end
  endtask

  // one clock edge: advance the model, then compare all outputs 1ns later
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_step(0, raw_h);
      model_step(1, ~raw_l);
    end
    #1;
    check("lvl_h", lvl_h, m_level[0]);
    check("prs_h", prs_h, m_press[0]);
    check("rel_h", rel_h, m_rel[0]);
    check("lvl_l", lvl_l, m_level[1]);
    check("prs_l", prs_l, m_press[1]);
    check("rel_l", rel_l, m_rel[1]);
    check("excl_h", prs_h & rel_h, '0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_lvl", lvl_h | lvl_l, '0);
    check("rst_pls", prs_h | rel_h | prs_l | rel_l, '0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();

    // 1: reset with all pins pressed, then release and count edges
    raw_h = 3'b111;
    #2;
    check("t1_rst_lvl", lvl_h, 3'b000);
    check("t1_rst_prs", prs_h | rel_h, 3'b000);
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("t1_early", lvl_h, 3'b000);
    end
    tick();
    check("t1_edge6_lvl", lvl_h, 3'b111);
    check("t1_edge6_prs", prs_h, 3'b111);
    tick();
    check("t1_edge7_prs", prs_h, 3'b000);
    check("t6_idle", lvl_l, 3'b000);

    // 6: active-low instance, hold pin 1 low
    raw_l[1] = 1'b0;
    ticks(5);
    check("t6_early", lvl_l, 3'b000);
    tick();
    check("t6_edge6_lvl", lvl_l, 3'b010);
    check("t6_edge6_prs", prs_l, 3'b010);
    ticks(2);

    // 2: bounce on channel 0 starting from released
    raw_h[0] = 1'b0;
    ticks(8);
    check("t2_start", lvl_h, 3'b110);
    begin
      logic [7:0] pat;
      pat = 8'b1111_0111;
      for (int i = 0; i < 8; i++) begin
        raw_h[0] = pat[i];
        tick();
        check("t2_norel", rel_h, 3'b000);
      end
    end
    ticks(3);
    check("t2_end", lvl_h, 3'b111);

    // 3: drop channel 1 from pressed
    raw_h[1] = 1'b0;
    ticks(5);
    check("t3_early", lvl_h, 3'b111);
    tick();
    check("t3_edge6_lvl", lvl_h, 3'b101);
    check("t3_edge6_rel", rel_h, 3'b010);
    check("t3_edge6_prs", prs_h, 3'b000);

    // 4: channels 0 and 2 rise together
    raw_h = 3'b000;
    ticks(8);
    raw_h = 3'b101;
    ticks(5);
    tick();
    check("t4_prs", prs_h, 3'b101);
    check("t4_lvl", lvl_h, 3'b101);

    // 5: reset in the middle of a count discards it
    raw_h = 3'b000;
    ticks(8);
    raw_h = 3'b100;
    ticks(3);
    check("t5_before", lvl_h, 3'b000);
    pulse_reset();
    ticks(5);
    check("t5_early", lvl_h, 3'b000);
    tick();
    check("t5_edge6_prs", prs_h, 3'b100);

    // random stimulus with mostly-held pins and occasional bursts of bounce
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int mode;
      mode = (cyc / 100) % 3;
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(mode == 0 ? 2 : 12, 0) == 0) raw_h[c] = ~raw_h[c];
        if ($urandom_range(mode == 1 ? 2 : 10, 0) == 0) raw_l[c] = ~raw_l[c];
      end
      if ($urandom_range(700, 0) == 0) pulse_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
